// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types and helpers for the two-way intersection controller:
// phase encodings, lamp patterns and the fixed phase order.
package traffic_light_ctrl_pkg;

    localparam int COUNT_W   = 6;
    localparam int COUNT_MAX = 59;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } state_e;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamps_t;

    localparam lamps_t LAMPS_ALL_RED = '{ns: LAMP_R, ew: LAMP_R};

    // Unused encodings fall into ALLRED_B so the cycle recovers through a clearance phase.
    function automatic state_e next_phase(input state_e s);
        state_e n;
        case (s)
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = ALLRED_A;
            ALLRED_A:  n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = ALLRED_B;
            ALLRED_B:  n = NS_GREEN;
            default:   n = ALLRED_B;
        endcase
        return n;
    endfunction

    function automatic lamps_t lamps_for(input state_e s);
        lamps_t l;
        case (s)
            NS_GREEN:  l = '{ns: LAMP_G, ew: LAMP_R};
            NS_YELLOW: l = '{ns: LAMP_Y, ew: LAMP_R};
            EW_GREEN:  l = '{ns: LAMP_R, ew: LAMP_G};
            EW_YELLOW: l = '{ns: LAMP_R, ew: LAMP_Y};
            default:   l = LAMPS_ALL_RED;
        endcase
        return l;
    endfunction

    function automatic logic is_green(input state_e s);
        return (s == NS_GREEN) || (s == EW_GREEN);
    endfunction

    function automatic logic is_allred(input state_e s);
        return (s == ALLRED_A) || (s == ALLRED_B);
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// Once-per-second strobe: a prescaler counting 0..CLK_HZ-1, with tick high
// combinationally during the last count of each period.
module tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller: phase FSM, per-phase seconds countdown,
// latched pedestrian request that shortens green, and registered lamp drives.
module traffic_light_ctrl
    import traffic_light_ctrl_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int GREEN_S   = 30,
    parameter int YELLOW_S  = 4,
    parameter int ALLRED_S  = 2,
    parameter int PED_MIN_S = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ped_req,
    output logic [2:0]         ns_light,
    output logic [2:0]         ew_light,
    output logic [COUNT_W-1:0] count,
    output logic               ped_wait,
    output logic               tick
);

    if (CLK_HZ < 2) begin : g_bad_clk_hz
        $error("traffic_light_ctrl: CLK_HZ must be >= 2");
    end
    if (GREEN_S < 1 || GREEN_S > COUNT_MAX) begin : g_bad_green
        $error("traffic_light_ctrl: GREEN_S must be 1..59");
    end
    if (YELLOW_S < 1 || YELLOW_S > COUNT_MAX) begin : g_bad_yellow
        $error("traffic_light_ctrl: YELLOW_S must be 1..59");
    end
    if (ALLRED_S < 1 || ALLRED_S > COUNT_MAX) begin : g_bad_allred
        $error("traffic_light_ctrl: ALLRED_S must be 1..59");
    end
    if (PED_MIN_S < 1 || PED_MIN_S > GREEN_S) begin : g_bad_ped_min
        $error("traffic_light_ctrl: PED_MIN_S must be 1..GREEN_S");
    end

    localparam logic [COUNT_W-1:0] GREEN_C   = COUNT_W'(GREEN_S);
    localparam logic [COUNT_W-1:0] YELLOW_C  = COUNT_W'(YELLOW_S);
    localparam logic [COUNT_W-1:0] ALLRED_C  = COUNT_W'(ALLRED_S);
    localparam logic [COUNT_W-1:0] PED_MIN_C = COUNT_W'(PED_MIN_S);

    function automatic logic [COUNT_W-1:0] phase_dur(input state_e s);
        logic [COUNT_W-1:0] d;
        case (s)
            NS_GREEN, EW_GREEN:   d = GREEN_C;
            NS_YELLOW, EW_YELLOW: d = YELLOW_C;
            default:              d = ALLRED_C;
        endcase
        return d;
    endfunction

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ped_wait_q, ped_wait_d;
    lamps_t             lamps_q, lamps_d;
    logic               tick_w;

    tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ALLRED_B;
            count_q    <= ALLRED_C;
            ped_wait_q <= 1'b0;
            lamps_q    <= LAMPS_ALL_RED;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ped_wait_q <= ped_wait_d;
            lamps_q    <= lamps_d;
        end
    end

    // count <= 1 (not == 1) so a corrupted zero advances instead of wrapping to 63.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        count_d    = count_q;
        ped_wait_d = ped_wait_q | ped_req;
        if (tick_w) begin
            if (count_q <= COUNT_W'(1)) begin
                state_d = next_phase(state_q);
                count_d = phase_dur(state_d);
                if (is_allred(state_d) && !ped_req) begin
                    ped_wait_d = 1'b0;
                end
            end else if (is_green(state_q) && ped_wait_q && (count_q > PED_MIN_C)) begin
                count_d = PED_MIN_C;
            end else begin
                count_d = count_q - COUNT_W'(1);
            end
        end
    end

    // Lamps derive from the next state so they register on the same edge as the phase change.
    always_comb begin
        lamps_d = lamps_for(state_d);
    end

    assign ns_light = lamps_q.ns;
    assign ew_light = lamps_q.ew;
    assign count    = count_q;
    assign ped_wait = ped_wait_q;
    assign tick     = tick_w;

endmodule
